avr_rr_arb: RTL



---
 rtl/avr_rr_arb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/avr_rr_arb.sv
// N-to-1 round-robin arbiter for AVR valid/ready streams; combinational data path, zero-latency grant.
// Grant is frozen while downstream stalls; optional packet mode (macro AVR_ARB_LAST_EN) holds grant until s_last.
module avr_rr_arb #(
  parameter int N  = 4,
  parameter int DW = 256,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*DW-1:0] m_data,
  input  logic [N-1:0]    m_valid,
  output logic [N-1:0]    m_ready,
  output logic [DW-1:0]   s_data,
  output logic            s_valid,
  input  logic            s_ready,
  output logic [IW-1:0]   s_id
`ifdef AVR_ARB_LAST_EN
  ,
  input  logic [N-1:0]    m_last,
  output logic            s_last
`endif
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic          lock_q, lock_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_cur;
  logic [IW-1:0] gnt_scan;
  logic [IW-1:0] gnt_inc;
  logic          found;
  logic [IW:0]   sum;
  logic          hs;
  logic          stall;
  logic          recover;
`ifdef AVR_ARB_LAST_EN
  logic          pkt_q, pkt_d;
`endif

  // Rotating priority scan starting at ptr; falls back to ptr when idle.
  always_comb begin
    gnt_scan = ptr_q;
    found    = 1'b0;
    sum      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      if (!found && m_valid[sum[IW-1:0]]) begin
        gnt_scan = sum[IW-1:0];
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_cur = lock_q ? gnt_q : gnt_scan;
    s_valid = m_valid[gnt_cur];
    s_id    = gnt_cur;
    s_data  = '0;
    m_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_cur == IW'(i)) begin
        s_data     = m_data[i*DW +: DW];
        m_ready[i] = s_ready & s_valid;
      end
    end
    gnt_inc = (gnt_cur == LAST_IDX) ? '0 : gnt_cur + IW'(1);
    hs      = s_valid & s_ready;
    stall   = s_valid & ~s_ready;
    recover = lock_q & ~m_valid[gnt_q];
  end

`ifdef AVR_ARB_LAST_EN
  assign s_last = m_last[gnt_cur];
`endif

  always_comb begin
    lock_d = lock_q;
    gnt_d  = gnt_q;
    ptr_d  = ptr_q;
`ifdef AVR_ARB_LAST_EN
    pkt_d  = pkt_q;
    if (hs) begin
      if (s_last) begin
        lock_d = 1'b0;
        pkt_d  = 1'b0;
        ptr_d  = gnt_inc;
      end else begin
        lock_d = 1'b1;
        pkt_d  = 1'b1;
        gnt_d  = gnt_cur;
      end
    end else if (stall) begin
      lock_d = 1'b1;
      gnt_d  = gnt_cur;
    end else if (recover && !pkt_q) begin
      lock_d = 1'b0;
    end
`else
    if (hs) begin
      lock_d = 1'b0;
      ptr_d  = gnt_inc;
    end else if (stall) begin
      lock_d = 1'b1;
      gnt_d  = gnt_cur;
    end else if (recover) begin
      // Upstream dropped valid while locked: release without advancing.
      lock_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
      gnt_q  <= '0;
      ptr_q  <= '0;
`ifdef AVR_ARB_LAST_EN
      pkt_q  <= 1'b0;
`endif
    end else begin
      lock_q <= lock_d;
      gnt_q  <= gnt_d;
      ptr_q  <= ptr_d;
`ifdef AVR_ARB_LAST_EN
      pkt_q  <= pkt_d;
`endif
    end
  end

endmodule
